// File: rtl/mips_cpu_bus_pkg.sv
// mips_cpu_bus_pkg
//   Shared types and helpers for the CPU bus initiator.
//   - size_t      : access size of a data request (byte / half / word)
//   - bus_state_t : states of the initiator FSM
//   - is_misaligned() : flags half/word requests that straddle their natural boundary
package mips_cpu_bus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUS     = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } bus_state_t;

  // The undefined size code 2'b11 is handled like a word everywhere.
  function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return offset[0];
      default: return |offset;
    endcase
  endfunction

endpackage

// File: rtl/mips_cpu_lane_align.sv
// mips_cpu_lane_align
//   Combinational little-endian lane steering between the core and the 32-bit bus.
//   Ports:
//     size, offset, sign_ext : access size, byte offset within the word, load extension mode
//     wdata      -> writedata : right-aligned store data shifted onto its lanes, other lanes 0
//     rdata      -> rdata_ext : bus word shifted down, masked to size and extended
//     byteenable              : lane mask, byteenable[k] covers bits [8k+7:8k]
module mips_cpu_lane_align
  import mips_cpu_bus_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata_ext
);

  logic [31:0] wshift;
  logic [31:0] rshift;
  logic [31:0] lane_mask;

  // NOTE: every output of a combinational block gets a value on every path
  // (case defaults included); a missed path would infer a latch.
  always_comb begin
    case (size_t'(size))
      BYTE:    byteenable = 4'b0001 << offset;
      HALF:    byteenable = offset[1] ? 4'b1100 : 4'b0011;
      default: byteenable = 4'b1111;
    endcase

    for (int k = 0; k < 4; k++) begin
      lane_mask[8*k +: 8] = {8{byteenable[k]}};
    end
    wshift    = wdata << {offset, 3'b000};
    writedata = wshift & lane_mask;

    rshift = rdata >> {offset, 3'b000};
    case (size_t'(size))
      BYTE:    rdata_ext = {{24{sign_ext & rshift[7]}}, rshift[7:0]};
      HALF:    rdata_ext = {{16{sign_ext & rshift[15]}}, rshift[15:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_initiator.sv
// mips_cpu_bus_initiator
//   Arbitrates instruction-fetch and load/store requests onto a waitrequest-style
//   32-bit memory bus, one transaction at a time.
//   Ports:
//     clk, reset_n                          : clock, synchronous active-low reset
//     if_req/if_addr -> if_accept           : fetch request handshake (accept is combinational)
//     if_rvalid/if_rdata                    : one-cycle fetch response
//     d_req/d_we/d_addr/d_size/d_signed/d_wdata -> d_accept : data request handshake
//     d_rvalid/d_rdata/d_err                : one-cycle data response or misalignment error
//     address/read/write/writedata/byteenable/waitrequest/readdata : memory bus
module mips_cpu_bus_initiator
  import mips_cpu_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_accept,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic        d_accept,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  bus_state_t  state_q, state_d;
  logic        read_q, read_d, write_q, write_d;
  logic [31:0] address_q, address_d, writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  // Context of the accepted request, needed again when the response is built.
  logic        is_data_q, is_data_d, we_q, we_d, signed_q, signed_d;
  size_t       size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic [31:0] rdata_raw_q, rdata_raw_d;

  logic        take_data, take_fetch;
  size_t       la_size;
  logic [1:0]  la_offset;
  logic        la_signed;
  logic [3:0]  la_be;
  logic [31:0] la_wdata, la_rdata;
  logic [1:0]  unused_if_addr_bits;

  // Fetches are always whole words, so the low fetch address bits carry no meaning.
  assign unused_if_addr_bits = if_addr[1:0];

  assign take_data  = d_req && (DATA_PRIORITY || !if_req);
  assign take_fetch = if_req && !take_data;
  assign d_accept   = reset_n && (state_q == IDLE) && take_data;
  assign if_accept  = reset_n && (state_q == IDLE) && take_fetch;

  // One aligner serves both directions: in IDLE it shapes the incoming request,
  // afterwards it decodes read data using the latched request context.
  always_comb begin
    if (state_q == IDLE) begin
      la_size   = take_data ? size_t'(d_size) : WORD;
      la_offset = take_data ? d_addr[1:0] : 2'b00;
      la_signed = d_signed;
    end else begin
      la_size   = size_q;
      la_offset = offset_q;
      la_signed = signed_q;
    end
  end

  mips_cpu_lane_align u_lane_align (
    .size       (la_size),
    .offset     (la_offset),
    .sign_ext   (la_signed),
    .wdata      (d_wdata),
    .rdata      (rdata_raw_q),
    .byteenable (la_be),
    .writedata  (la_wdata),
    .rdata_ext  (la_rdata)
  );

  always_comb begin
    state_d      = state_q;
    read_d       = read_q;
    write_d      = write_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    is_data_d    = is_data_q;
    we_d         = we_q;
    signed_d     = signed_q;
    size_d       = size_q;
    offset_d     = offset_q;
    rdata_raw_d  = rdata_raw_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    d_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_accept) begin
          is_data_d = 1'b1;
          we_d      = d_we;
          size_d    = size_t'(d_size);
          signed_d  = d_signed;
          offset_d  = d_addr[1:0];
          if (is_misaligned(size_t'(d_size), d_addr[1:0])) begin
            // Rejected without touching the bus.
            d_err_d = 1'b1;
          end else begin
            state_d      = BUS;
            address_d    = {d_addr[31:2], 2'b00};
            byteenable_d = la_be;
            read_d       = !d_we;
            write_d      = d_we;
            if (d_we) writedata_d = la_wdata;
          end
        end else if (if_accept) begin
          is_data_d    = 1'b0;
          we_d         = 1'b0;
          size_d       = WORD;
          signed_d     = 1'b0;
          offset_d     = 2'b00;
          state_d      = BUS;
          address_d    = {if_addr[31:2], 2'b00};
          byteenable_d = 4'b1111;
          read_d       = 1'b1;
          write_d      = 1'b0;
        end
      end
      BUS: begin
        // A strobe is always high here; the slave accepts when it stops stalling.
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = write_q ? RESP : CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_raw_d = readdata;
        state_d     = RESP;
      end
      RESP: begin
        if (is_data_q) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = we_q ? 32'h0 : la_rdata;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = la_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= 32'h0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'h0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= 32'h0;
      d_err_q      <= 1'b0;
      is_data_q    <= 1'b0;
      we_q         <= 1'b0;
      signed_q     <= 1'b0;
      size_q       <= WORD;
      offset_q     <= 2'b00;
      rdata_raw_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
      is_data_q    <= is_data_d;
      we_q         <= we_d;
      signed_q     <= signed_d;
      size_q       <= size_d;
      offset_q     <= offset_d;
      rdata_raw_q  <= rdata_raw_d;
    end
  end

  assign read       = read_q;
  assign write      = write_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign d_rvalid   = d_rvalid_q;
  assign d_rdata    = d_rdata_q;
  assign d_err      = d_err_q;

endmodule

// File: tb/tb_mips_cpu_bus_initiator.sv
// tb_mips_cpu_bus_initiator
//   Directed bench for mips_cpu_bus_initiator with a small word-addressed memory
//   slave (32 words, indexed by address[6:2]) driving readdata one cycle after
//   each accepted read.
module tb_mips_cpu_bus_initiator;
  import mips_cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_accept, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we, d_signed;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_accept, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  logic [31:0] mem [0:31];
  logic        mem_load;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_initiator #(.DATA_PRIORITY(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_accept(if_accept),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size),
    .d_signed(d_signed), .d_wdata(d_wdata), .d_accept(d_accept),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  // Memory slave.
  always @(posedge clk) begin
    if (mem_load) begin
      mem[0] <= 32'h1234_5678;   // 0xBFC00000
      mem[1] <= 32'h1122_3344;   // 0xBFC00004
      mem[2] <= 32'h8001_1234;   // 0xBFC00008
    end else begin
      if (read && !waitrequest) readdata <= mem[address[6:2]];
      if (write && !waitrequest) begin
        for (int k = 0; k < 4; k++)
          if (byteenable[k]) mem[address[6:2]][8*k +: 8] <= writedata[8*k +: 8];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_size = 2'b00;
    d_signed = 1'b0; d_wdata = 32'h0;
  endtask

  task automatic start_data(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] wd);
    d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_signed = sgn; d_wdata = wd;
    #1;
  endtask

  // Counts edges from the current cycle until the selected rvalid is seen (bounded).
  task automatic wait_rvalid(input bit is_data, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!(is_data ? d_rvalid : if_rvalid) && n < 20);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; waitrequest = 1'b0; mem_load = 1'b1;
    idle_inputs();
    repeat (3) cyc();
    n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", read); end
    n_checks++; if (write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", write); end
    n_checks++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", address); end
    n_checks++; if (writedata !== 32'h0) begin n_fail++; $display("FAIL reset_writedata: got %h want 0", writedata); end
    n_checks++; if (byteenable !== 4'h0) begin n_fail++; $display("FAIL reset_byteenable: got %b want 0000", byteenable); end
    n_checks++; if ({if_rvalid, d_rvalid, d_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {if_rvalid, d_rvalid, d_err}); end
    n_checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, d_rdata); end
    reset_n = 1'b1; mem_load = 1'b0;
    cyc();
  endtask

  task automatic test_fetch();
    int n;
    if_req = 1'b1; if_addr = 32'hBFC0_0000; #1;
    n_checks++; if (if_accept !== 1'b1 || d_accept !== 1'b0) begin n_fail++; $display("FAIL fetch_accept: got if=%b d=%b want 1/0", if_accept, d_accept); end
    cyc(); if_req = 1'b0;
    n_checks++; if ({read, write} !== 2'b10) begin n_fail++; $display("FAIL fetch_strobe: got rd=%b wr=%b want 1/0", read, write); end
    n_checks++; if (address !== 32'hBFC0_0000) begin n_fail++; $display("FAIL fetch_address: got %h want bfc00000", address); end
    n_checks++; if (byteenable !== 4'b1111) begin n_fail++; $display("FAIL fetch_be: got %b want 1111", byteenable); end
    wait_rvalid(1'b0, n);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL fetch_latency: got %0d want 3", n); end
    n_checks++; if (if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL fetch_rdata: got %h want 12345678", if_rdata); end
    cyc();
    n_checks++; if (if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_rvalid_pulse: got %b want 0", if_rvalid); end
  endtask

  task automatic test_store_byte();
    int n;
    start_data(1'b1, 32'hBFC0_0007, BYTE, 1'b0, 32'h1234_56AB);
    n_checks++; if (d_accept !== 1'b1) begin n_fail++; $display("FAIL sb_accept: got %b want 1", d_accept); end
    cyc(); d_req = 1'b0;
    n_checks++; if ({read, write} !== 2'b01) begin n_fail++; $display("FAIL sb_strobe: got rd=%b wr=%b want 0/1", read, write); end
    n_checks++; if (address !== 32'hBFC0_0004) begin n_fail++; $display("FAIL sb_address: got %h want bfc00004", address); end
    n_checks++; if (byteenable !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", byteenable); end
    n_checks++; if (writedata !== 32'hAB00_0000) begin n_fail++; $display("FAIL sb_writedata: got %h want ab000000", writedata); end
    wait_rvalid(1'b1, n);
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL sb_latency: got %0d want 2", n); end
    n_checks++; if (d_rdata !== 32'h0) begin n_fail++; $display("FAIL sb_rdata: got %h want 0", d_rdata); end
    cyc();
    start_data(1'b0, 32'hBFC0_0004, WORD, 1'b0, 32'h0);
    cyc(); d_req = 1'b0;
    wait_rvalid(1'b1, n);
    n_checks++; if (d_rdata !== 32'hAB22_3344) begin n_fail++; $display("FAIL sb_readback: got %h want ab223344", d_rdata); end
    cyc();
  endtask

  task automatic test_load_ext();
    int n;
    logic [31:0] t_addr [4] = '{32'hBFC0_000A, 32'hBFC0_000A, 32'hBFC0_0008, 32'hBFC0_000B};
    logic [1:0]  t_size [4] = '{HALF, HALF, BYTE, BYTE};
    logic        t_sgn  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  t_be   [4] = '{4'b1100, 4'b1100, 4'b0001, 4'b1000};
    logic [31:0] t_exp  [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_0034, 32'hFFFF_FF80};
    for (int i = 0; i < 4; i++) begin
      start_data(1'b0, t_addr[i], t_size[i], t_sgn[i], 32'h0);
      cyc(); d_req = 1'b0;
      n_checks++; if (byteenable !== t_be[i]) begin n_fail++; $display("FAIL load%0d_be: got %b want %b", i, byteenable, t_be[i]); end
      wait_rvalid(1'b1, n);
      n_checks++; if (n !== 3 || d_rdata !== t_exp[i]) begin n_fail++; $display("FAIL load%0d_rdata: got %h after %0d want %h after 3", i, d_rdata, n, t_exp[i]); end
      cyc();
    end
  endtask

  task automatic test_waitrequest();
    int n;
    waitrequest = 1'b1;
    if_req = 1'b1; if_addr = 32'hBFC0_0000; #1;
    cyc(); if_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({read, write, address, byteenable} !== {1'b1, 1'b0, 32'hBFC0_0000, 4'hF}) begin
        n_fail++; $display("FAIL wait_hold%0d: got rd=%b wr=%b a=%h be=%b want 1/0/bfc00000/1111", i, read, write, address, byteenable);
      end
      cyc();
    end
    waitrequest = 1'b0;
    n_checks++; if ({read, address} !== {1'b1, 32'hBFC0_0000}) begin n_fail++; $display("FAIL wait_hold_last: got rd=%b a=%h want 1/bfc00000", read, address); end
    wait_rvalid(1'b0, n);
    n_checks++; if (5 + n !== 8) begin n_fail++; $display("FAIL wait_latency: got %0d want 8", 5 + n); end
    n_checks++; if (if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wait_rdata: got %h want 12345678", if_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back();
    int n;
    if_req = 1'b1; if_addr = 32'hBFC0_0000;
    start_data(1'b0, 32'hBFC0_0008, WORD, 1'b0, 32'h0);
    n_checks++; if ({d_accept, if_accept} !== 2'b10) begin n_fail++; $display("FAIL prio_accept: got d=%b if=%b want 1/0", d_accept, if_accept); end
    cyc(); d_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      n_checks++; if (if_accept !== 1'b0) begin n_fail++; $display("FAIL prio_busy%0d: got if_accept=%b want 0", i, if_accept); end
      cyc();
    end
    n_checks++; if ({d_rvalid, if_accept} !== 2'b11) begin n_fail++; $display("FAIL prio_resp_idle: got rvalid=%b if_accept=%b want 1/1", d_rvalid, if_accept); end
    n_checks++; if (d_rdata !== 32'h8001_1234) begin n_fail++; $display("FAIL prio_rdata: got %h want 80011234", d_rdata); end
    cyc(); if_req = 1'b0;
    n_checks++; if ({read, address} !== {1'b1, 32'hBFC0_0000}) begin n_fail++; $display("FAIL prio_fetch_bus: got rd=%b a=%h want 1/bfc00000", read, address); end
    wait_rvalid(1'b0, n);
    n_checks++; if (n !== 3 || if_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL prio_fetch_rdata: got %h after %0d want 12345678 after 3", if_rdata, n); end
    cyc();
  endtask

  task automatic test_misaligned();
    start_data(1'b0, 32'hBFC0_0009, HALF, 1'b1, 32'h0);
    n_checks++; if (d_accept !== 1'b1) begin n_fail++; $display("FAIL mis_half_accept: got %b want 1", d_accept); end
    cyc(); d_req = 1'b0;
    n_checks++; if ({d_err, read, write, d_rvalid} !== 4'b1000) begin n_fail++; $display("FAIL mis_half_err: got err/rd/wr/rv=%b want 1000", {d_err, read, write, d_rvalid}); end
    cyc();
    n_checks++; if ({d_err, read, write} !== 3'b000) begin n_fail++; $display("FAIL mis_half_pulse: got err/rd/wr=%b want 000", {d_err, read, write}); end
    start_data(1'b1, 32'hBFC0_000A, WORD, 1'b0, 32'hDEAD_BEEF);
    cyc(); d_req = 1'b0;
    n_checks++; if ({d_err, read, write} !== 3'b100) begin n_fail++; $display("FAIL mis_word_err: got err/rd/wr=%b want 100", {d_err, read, write}); end
    cyc();
    n_checks++; if ({d_err, write} !== 2'b00) begin n_fail++; $display("FAIL mis_word_pulse: got err/wr=%b want 00", {d_err, write}); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    start_data(1'b0, 32'hBFC0_0004, WORD, 1'b0, 32'h0);
    cyc(); d_req = 1'b0;
    n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL rstmid_bus: got rd=%b want 1", read); end
    reset_n = 1'b0;
    cyc();
    n_checks++; if ({read, write} !== 2'b00) begin n_fail++; $display("FAIL rstmid_strobe: got rd=%b wr=%b want 0/0", read, write); end
    cyc(); reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      seen = seen | d_rvalid | if_rvalid;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_resp: got rvalid seen=%b want 0", seen); end
    start_data(1'b0, 32'hBFC0_0004, WORD, 1'b0, 32'h0);
    n_checks++; if (d_accept !== 1'b1) begin n_fail++; $display("FAIL rstmid_reaccept: got %b want 1", d_accept); end
    cyc(); d_req = 1'b0;
    wait_rvalid(1'b1, n);
    n_checks++; if (n !== 3 || d_rdata !== 32'hAB22_3344) begin n_fail++; $display("FAIL rstmid_rdata: got %h after %0d want ab223344 after 3", d_rdata, n); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_byte();
    test_load_ext();
    test_waitrequest();
    test_back_to_back();
    test_misaligned();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
